sdram_init_seq: RTL and testbench



---
 rtl/sdram_init_seq.sv | 130 +++++++++++++
 tb/tb_sdram_init_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: parametrised SDRAM power-up / re-init command sequencer
module sdram_init_seq #(
    parameter int          ADDR_W        = 13,
    parameter int          BANK_W        = 2,
    parameter int          T_POWERUP_CYC = 20000,
    parameter int          T_CKE_CYC     = 100,
    parameter int          T_RP_CYC      = 2,
    parameter int          T_RFC_CYC     = 7,
    parameter int          T_MRD_CYC     = 2,
    parameter int          AR_COUNT      = 2,
    parameter int          EMRS_EN       = 0,
    parameter logic [BANK_W-1:0] EMRS_BANK = 2'b10
) (
    input  logic              init_clk,
    input  logic              init_rst_n,
    input  logic              init_req,
    input  logic [ADDR_W-1:0] init_mr,
    input  logic [ADDR_W-1:0] init_emr,
    output logic [3:0]        init_cmd,
    output logic [BANK_W-1:0] init_bank,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_cke,
    output logic              init_busy,
    output logic              init_end
);
    localparam int PW_MIN = $clog2(T_POWERUP_CYC + 1);
    localparam int PW     = PW_MIN > 16 ? PW_MIN : 16;
    localparam int T_MAX1 = T_RP_CYC > T_RFC_CYC ? T_RP_CYC : T_RFC_CYC;
    localparam int T_MAX  = T_MAX1 > T_MRD_CYC ? T_MAX1 : T_MRD_CYC;
    localparam int TW     = $clog2(T_MAX + 1);
    localparam int RW     = $clog2(AR_COUNT + 1);

    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [3:0] {
        S_PWR, S_PRE, S_TRP, S_AR, S_TRFC, S_MRS, S_TMRD,
        S_EMRS, S_TEMRS, S_DONE, S_REINIT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [ADDR_W-1:0] mr_q, mr_d, emr_q, emr_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cke_q, cke_d, end_q, end_d, sample;

    // next state, counters and registered-output values decoded from the next state
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q + 1'b1;
        sample  = 1'b0;
        case (state_q)
            S_PWR: begin
                pcnt_d = pcnt_q + 1'b1;
                if (pcnt_q == PW'(T_POWERUP_CYC - 1)) begin
                    state_d = S_PRE;
                    sample  = 1'b1;
                end
            end
            S_PRE, S_TRP:   state_d = tcnt_q == TW'(T_RP_CYC - 1) ? S_AR : S_TRP;
            S_AR, S_TRFC:   state_d = tcnt_q != TW'(T_RFC_CYC - 1) ? S_TRFC :
                                      rcnt_q == RW'(AR_COUNT) ? S_MRS : S_AR;
            S_MRS, S_TMRD:  state_d = tcnt_q != TW'(T_MRD_CYC - 1) ? S_TMRD :
                                      EMRS_EN != 0 ? S_EMRS : S_DONE;
            S_EMRS, S_TEMRS: state_d = tcnt_q == TW'(T_MRD_CYC - 1) ? S_DONE : S_TEMRS;
            S_DONE: begin
                if (init_req) begin
                    state_d = S_REINIT;
                    sample  = 1'b1;
                end
            end
            S_REINIT:       state_d = S_PRE;
            default:        state_d = S_PWR;
        endcase
        if (state_d inside {S_PRE, S_AR, S_MRS, S_EMRS}) tcnt_d = '0;
        rcnt_d = state_d == S_PRE ? '0 : state_d == S_AR ? rcnt_q + 1'b1 : rcnt_q;
        mr_d   = sample ? init_mr : mr_q;
        emr_d  = sample ? init_emr : emr_q;
        cke_d  = cke_q | (state_q == S_PWR && pcnt_q == PW'(T_CKE_CYC - 1));
        cmd_d  = state_d == S_PRE ? CMD_PRE :
                 state_d == S_AR ? CMD_AR :
                 state_d inside {S_MRS, S_EMRS} ? CMD_MRS : CMD_NOP;
        bank_d = state_d == S_MRS ? '0 : state_d == S_EMRS ? EMRS_BANK : '1;
        addr_d = state_d == S_MRS ? mr_q : state_d == S_EMRS ? emr_q : '1;
        end_d  = state_d == S_DONE;
    end

    // state, counters, sampled mode values and all outputs
    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_q <= S_PWR;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            rcnt_q  <= '0;
            mr_q    <= '0;
            emr_q   <= '0;
            cmd_q   <= CMD_NOP;
            bank_q  <= '1;
            addr_q  <= '1;
            cke_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            rcnt_q  <= rcnt_d;
            mr_q    <= mr_d;
            emr_q   <= emr_d;
            cmd_q   <= cmd_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            cke_q   <= cke_d;
            end_q   <= end_d;
        end
    end

    assign init_cmd  = cmd_q;
    assign init_bank = bank_q;
    assign init_addr = addr_q;
    assign init_cke  = cke_q;
    assign init_end  = end_q;
    assign init_busy = ~end_q;
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: scoreboard bench for three sdram_init_seq configurations
module tb_sdram_init_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic [12:0] mr = 13'h037;
    logic [12:0] emr = 13'h020;
    logic [3:0] cmd_a, cmd_b, cmd_c;
    logic [1:0] bank_a, bank_b, bank_c;
    logic [12:0] addr_a, addr_b, addr_c;
    logic cke_a, cke_b, cke_c, busy_a, busy_b, busy_c, end_a, end_b, end_c;
    logic [21:0] q[$];
    int total = 0;
    int passed = 0;
    localparam logic [21:0] RST_V = {4'b0111, 2'b11, 13'h1FFF, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    sdram_init_seq #(.T_POWERUP_CYC(20), .T_CKE_CYC(5)) dut_a (
        .init_clk(clk), .init_rst_n(rst_n), .init_req(req), .init_mr(mr), .init_emr(emr),
        .init_cmd(cmd_a), .init_bank(bank_a), .init_addr(addr_a), .init_cke(cke_a),
        .init_busy(busy_a), .init_end(end_a));
    sdram_init_seq #(.T_POWERUP_CYC(20), .T_CKE_CYC(5), .EMRS_EN(1)) dut_b (
        .init_clk(clk), .init_rst_n(rst_n), .init_req(req), .init_mr(mr), .init_emr(emr),
        .init_cmd(cmd_b), .init_bank(bank_b), .init_addr(addr_b), .init_cke(cke_b),
        .init_busy(busy_b), .init_end(end_b));
    sdram_init_seq #(.T_POWERUP_CYC(20), .T_CKE_CYC(5), .AR_COUNT(4), .T_RFC_CYC(1), .T_RP_CYC(1)) dut_c (
        .init_clk(clk), .init_rst_n(rst_n), .init_req(req), .init_mr(mr), .init_emr(emr),
        .init_cmd(cmd_c), .init_bank(bank_c), .init_addr(addr_c), .init_cke(cke_c),
        .init_busy(busy_c), .init_end(end_c));

    function automatic logic [21:0] model(int k, int pre, int ckt, int rp, int rfc, int mrd,
                                          int arn, bit emrs, logic [12:0] m, logic [12:0] e);
        logic [3:0] c;
        logic [1:0] b;
        logic [12:0] a;
        int mrs;
        int last;
        bit dn;
        c = 4'b0111;
        b = 2'b11;
        a = 13'h1FFF;
        mrs = pre + rp + arn * rfc;
        last = emrs ? mrs + mrd : mrs;
        dn = k >= last + mrd;
        if (k == pre) c = 4'b0010;
        for (int i = 0; i < arn; i++) if (k == pre + rp + i * rfc) c = 4'b0001;
        if (k == mrs) begin c = 4'b0000; b = 2'b00; a = m; end
        if (emrs && k == mrs + mrd) begin c = 4'b0000; b = 2'b10; a = e; end
        return {c, b, a, k >= ckt, ~dn, dn};
    endfunction

    task automatic check(string tag, int k, logic [21:0] obs);
        logic [21:0] exp_v;
        exp_v = q.pop_front();
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    endtask

    task automatic compare_all(int k);
        check("dut_a", k, {cmd_a, bank_a, addr_a, cke_a, busy_a, end_a});
        check("dut_b", k, {cmd_b, bank_b, addr_b, cke_b, busy_b, end_b});
        check("dut_c", k, {cmd_c, bank_c, addr_c, cke_c, busy_c, end_c});
    endtask

    task automatic chk_rst(int k);
        repeat (3) q.push_back(RST_V);
        compare_all(k);
    endtask

    task automatic tick(int k, int pre, int ckt, logic [12:0] m, logic [12:0] e);
        q.push_back(model(k, pre, ckt, 2, 7, 2, 2, 1'b0, m, e));
        q.push_back(model(k, pre, ckt, 2, 7, 2, 2, 1'b1, m, e));
        q.push_back(model(k, pre, ckt, 1, 1, 2, 4, 1'b0, m, e));
        @(posedge clk);
        #1;
        compare_all(k);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_rst(0);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            req = (k == 10 || k == 22);
            mr = k <= 20 ? 13'h037 : 13'h155;
            emr = k <= 20 ? 13'h020 : 13'h0AA;
            tick(k, 20, 5, 13'h037, 13'h020);
        end
        for (int k = 46; k <= 91; k++) begin
            req = (k == 46);
            mr = k == 46 ? 13'h027 : 13'h3FF;
            emr = k == 46 ? 13'h021 : 13'h3FF;
            tick(k, 47, 0, 13'h027, 13'h021);
        end
        req = 1'b0;
        rst_n = 1'b0;
        #1 chk_rst(92);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mr = 13'h037;
        emr = 13'h020;
        for (int k = 1; k <= 30; k++) tick(k, 20, 5, 13'h037, 13'h020);
        #1 rst_n = 1'b0;
        #1 chk_rst(30);
        @(posedge clk);
        #1 chk_rst(31);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) tick(k, 20, 5, 13'h037, 13'h020);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
